l2_cache_smi_scheduler: RTL and testbench
=========================================

Name: l2_cache_smi_scheduler

Overview:
Sequences all L2 system memory traffic.
- Accepts non-duplicate miss requests from the L2 read stage; duplicates are filtered upstream by the pending miss tracker.
- Queues the requests and runs each through an optional dirty-line writeback burst, then a fill burst.
- Returns the filled line to the L2 arbiter as a restart request.
- Exactly one system memory transaction is in flight at a time; requests are serviced in order.

Parameters:
QUEUE_SIZE, 8, miss queue depth; power of two, at least 2.
BURST_BEATS, 16, 32-bit beats per 512-bit line; fixed at 16.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  miss request offered
req_ready  out  1  queue can accept
req_address  in  26  line address to fill
req_dirty  in  1  victim line needs writeback
req_wb_address  in  26  victim line address
req_wb_data  in  512  victim line data
sm_request  out  1  system memory transaction active
sm_write  out  1  1 = writeback burst, 0 = fill burst
sm_address  out  32  {line_address, 6'b0}
sm_wdata  out  32  current write beat
sm_ack  in  1  one beat accepted (write) or returned (read)
sm_rdata  in  32  read beat, valid with sm_ack on fill
restart_valid  out  1  filled line ready
restart_ack  in  1  arbiter took restart
restart_address  out  26  filled line address
restart_data  out  512  filled line
pending_count  out  QUEUE_ADDR_WIDTH+1  occupied queue entries

Behaviour:
- Reset: queue empty, FSM in IDLE, beat counter 0, all outputs 0; fill buffer cleared.
- Queue: circular FIFO with head/tail pointers and a count.
  - req_ready = (count != QUEUE_SIZE).
  - Enqueue when req_valid && req_ready.
  - Dequeue on the cycle restart_valid && restart_ack.
  - Simultaneous enqueue and dequeue: count unchanged.
  - When full, req_ready stays 0 even on a dequeue cycle; no combinational ready-from-ack path.
  - Pointers wrap modulo QUEUE_SIZE.
- FSM states IDLE, WRITEBACK, FILL, RESTART:
  - IDLE: if count != 0, go to WRITEBACK when the head entry's dirty bit is set, else go to FILL. sm_request rises the cycle after entering the state.
  - WRITEBACK: sm_request=1, sm_write=1, sm_address={head.wb_address, 6'b0}, sm_wdata=head.wb_data[32*beat +: 32]. Each sm_ack increments beat. Ack on beat 15 → beat=0, go to FILL.
  - FILL: sm_request=1, sm_write=0, sm_address={head.address, 6'b0}. Each sm_ack writes sm_rdata into fill buffer slot [32*beat +: 32] and increments beat. Ack on beat 15 → go to RESTART.
  - RESTART: restart_valid=1; restart_address and restart_data hold stable until restart_ack. On ack, dequeue and go to IDLE.
- sm_address and sm_write are constant for a whole burst; sm_request drops for at least one cycle between bursts.
- Beat counter is 4 bits and wraps 15→0.
- sm_ack outside WRITEBACK/FILL is ignored.
- Reset asserted mid-burst: immediate abort, queue flushed, no restart issued; system memory must tolerate an abandoned burst.
- pending_count = count. It is registered and updates the cycle after an enqueue or dequeue.

Optional Feature:
L2_SMI_PERF_EN
- When defined, adds output perf_busy_cycles (32 bits): increments each cycle the FSM is not IDLE, saturates at 2^32-1, and is cleared by reset.
- Adds output perf_writebacks (16 bits): increments on entry to WRITEBACK, wraps.
- When undefined, neither port exists and no counter logic is built.

Decomposition:
- Shared package l2_cache_pkg holds: line width 512, beat width 32, BURST_BEATS, line address width 26, and the FSM state enum.
- Sub-module l2_smi_request_fifo holds the queue storage, pointers, count, full/empty.
- The FSM, beat counter and fill buffer remain in the top module.

Test Plan:
- Clean miss: enqueue address 26'h0000040, dirty=0, ack every cycle → 16 read beats at sm_address 32'h00001000; restart_valid 1 cycle after last ack with data matching beats; pending_count goes 1 → 0 after restart_ack.
- Dirty miss: wb_address 26'h0000010, wb_data beat k = k → 16 write beats at 32'h00000400 with sm_wdata = 0..15, then a fill at the req address; sm_request low ≥1 cycle between bursts.
- Full queue: 8 enqueues with sm_ack held 0 → req_ready=0 and pending_count=8; 9th offer not accepted. Complete one restart → req_ready returns 1 the next cycle.
- Back-pressure: hold restart_ack 0 for 10 cycles → restart_valid, restart_address and restart_data stable, no new sm_request.
- Reset mid-fill: assert reset_n=0 after beat 7 → all outputs 0 immediately, pending_count=0, no restart after release.
- With L2_SMI_PERF_EN: one dirty miss with ack every cycle → perf_writebacks=1 and perf_busy_cycles equal to the measured non-IDLE cycles.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared L2 cache types and constants: line/beat geometry, miss queue entry, SMI scheduler states.
package l2_cache_pkg;

    localparam int LINE_W        = 512;
    localparam int BEAT_W        = 32;
    localparam int BURST_BEATS   = 16;
    localparam int BEAT_IDX_W    = 4;
    localparam int LINE_ADDR_W   = 26;
    localparam int LINE_OFFSET_W = 6;
    localparam int SM_ADDR_W     = LINE_ADDR_W + LINE_OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2,
        ST_RESTART   = 2'd3
    } smi_state_t;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] address;
        logic                   dirty;
        logic [LINE_ADDR_W-1:0] wb_address;
        logic [LINE_W-1:0]      wb_data;
    } miss_entry_t;

endpackage

// File: rtl/l2_smi_request_fifo.sv
// Circular miss request queue for the SMI scheduler: storage, head/tail pointers and occupancy count.
module l2_smi_request_fifo
    import l2_cache_pkg::*;
#(
    parameter int QUEUE_SIZE       = 8,
    parameter int QUEUE_ADDR_WIDTH = $clog2(QUEUE_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  miss_entry_t               push_entry,
    input  logic                      pop,
    output miss_entry_t               head_entry,
    output logic [QUEUE_ADDR_WIDTH:0] count,
    output logic                      full,
    output logic                      empty
);
    localparam logic [QUEUE_ADDR_WIDTH:0] FULL_COUNT = (QUEUE_ADDR_WIDTH + 1)'(QUEUE_SIZE);

    miss_entry_t                 mem_q [QUEUE_SIZE];
    logic [QUEUE_ADDR_WIDTH-1:0] head_q, head_d;
    logic [QUEUE_ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [QUEUE_ADDR_WIDTH:0]   count_q, count_d;
    logic                        do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_entry;
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/l2_cache_smi_scheduler.sv
// L2 system memory scheduler: in-order miss queue, optional writeback burst, fill burst, restart to arbiter.
// Define L2_SMI_PERF_EN to add the perf_busy_cycles / perf_writebacks counters.
module l2_cache_smi_scheduler
    import l2_cache_pkg::*;
#(
    parameter int QUEUE_SIZE       = 8,
    parameter int QUEUE_ADDR_WIDTH = $clog2(QUEUE_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [LINE_ADDR_W-1:0]    req_address,
    input  logic                      req_dirty,
    input  logic [LINE_ADDR_W-1:0]    req_wb_address,
    input  logic [LINE_W-1:0]         req_wb_data,
    output logic                      sm_request,
    output logic                      sm_write,
    output logic [SM_ADDR_W-1:0]      sm_address,
    output logic [BEAT_W-1:0]         sm_wdata,
    input  logic                      sm_ack,
    input  logic [BEAT_W-1:0]         sm_rdata,
    output logic                      restart_valid,
    input  logic                      restart_ack,
    output logic [LINE_ADDR_W-1:0]    restart_address,
    output logic [LINE_W-1:0]         restart_data,
    output logic [QUEUE_ADDR_WIDTH:0] pending_count,
    output smi_state_t                state_dbg
`ifdef L2_SMI_PERF_EN
    ,
    output logic [31:0]               perf_busy_cycles,
    output logic [15:0]               perf_writebacks
`endif
);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_BEATS - 1);

    // Handshakes transfer on the rising edge where req_valid && req_ready, restart_valid &&
    // restart_ack, or sm_request && sm_ack (one beat); no valid ever waits on its ready/ack.
    miss_entry_t               head, push_entry;
    logic                      fifo_full, fifo_empty, push, pop;
    logic [QUEUE_ADDR_WIDTH:0] fifo_count;

    smi_state_t            state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic                  sm_req_q, sm_req_d;
    logic [LINE_W-1:0]     fill_q, fill_d;
    logic                  beat_done;

    assign push_entry    = {req_address, req_dirty, req_wb_address, req_wb_data};
    assign req_ready     = !fifo_full;
    assign push          = req_valid && req_ready;
    assign pop           = restart_valid && restart_ack;
    assign pending_count = fifo_count;
    assign state_dbg     = state_q;

    l2_smi_request_fifo #(
        .QUEUE_SIZE       (QUEUE_SIZE),
        .QUEUE_ADDR_WIDTH (QUEUE_ADDR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // sm_req_q only rises in WRITEBACK/FILL, so acks anywhere else never count.
    assign beat_done = sm_req_q && sm_ack;

    // Request is held low on the first cycle of each burst state, giving the inter-burst gap.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        sm_req_d = sm_req_q;
        fill_d   = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = head.dirty ? ST_WRITEBACK : ST_FILL;
            end
            ST_WRITEBACK: begin
                sm_req_d = 1'b1;
                if (beat_done) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        sm_req_d = 1'b0;
                        state_d  = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                sm_req_d = 1'b1;
                if (beat_done) begin
                    beat_d                          = beat_q + 1'b1;
                    fill_d[BEAT_W*beat_q +: BEAT_W] = sm_rdata;
                    if (beat_q == LAST_BEAT) begin
                        sm_req_d = 1'b0;
                        state_d  = ST_RESTART;
                    end
                end
            end
            ST_RESTART: begin
                if (restart_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            sm_req_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            sm_req_q <= sm_req_d;
            fill_q   <= fill_d;
        end
    end

    always_comb begin
        sm_request      = sm_req_q;
        sm_write        = 1'b0;
        sm_address      = '0;
        sm_wdata        = '0;
        restart_valid   = 1'b0;
        restart_address = '0;
        restart_data    = '0;
        case (state_q)
            ST_WRITEBACK: begin
                sm_write   = 1'b1;
                sm_address = {head.wb_address, {LINE_OFFSET_W{1'b0}}};
                sm_wdata   = head.wb_data[BEAT_W*beat_q +: BEAT_W];
            end
            ST_FILL: begin
                sm_address = {head.address, {LINE_OFFSET_W{1'b0}}};
            end
            ST_RESTART: begin
                restart_valid   = 1'b1;
                restart_address = head.address;
                restart_data    = fill_q;
            end
            default: ;
        endcase
    end

`ifdef L2_SMI_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [15:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        busy_d   = busy_q;
        wb_cnt_d = wb_cnt_q;
        if (state_q != ST_IDLE && busy_q != 32'hFFFF_FFFF) busy_d = busy_q + 1'b1;
        if (state_q != ST_WRITEBACK && state_d == ST_WRITEBACK) wb_cnt_d = wb_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            wb_cnt_q <= '0;
        end else begin
            busy_q   <= busy_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign perf_busy_cycles = busy_q;
    assign perf_writebacks  = wb_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache_smi_scheduler.sv
// Directed bench for l2_cache_smi_scheduler with a transaction-level reference model checked every cycle.
module tb_l2_cache_smi_scheduler;
    import l2_cache_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_dirty;
    logic [25:0]   req_address, req_wb_address;
    logic [511:0]  req_wb_data;
    logic          sm_request, sm_write, sm_ack;
    logic [31:0]   sm_address, sm_wdata, sm_rdata;
    logic          restart_valid, restart_ack;
    logic [25:0]   restart_address;
    logic [511:0]  restart_data;
    logic [3:0]    pending_count;
    smi_state_t    state_dbg;
`ifdef L2_SMI_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_writebacks;
`endif

    always #5 clk = ~clk;

    l2_cache_smi_scheduler #(.QUEUE_SIZE(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .req_dirty       (req_dirty),
        .req_wb_address  (req_wb_address),
        .req_wb_data     (req_wb_data),
        .sm_request      (sm_request),
        .sm_write        (sm_write),
        .sm_address      (sm_address),
        .sm_wdata        (sm_wdata),
        .sm_ack          (sm_ack),
        .sm_rdata        (sm_rdata),
        .restart_valid   (restart_valid),
        .restart_ack     (restart_ack),
        .restart_address (restart_address),
        .restart_data    (restart_data),
        .pending_count   (pending_count),
        .state_dbg       (state_dbg)
`ifdef L2_SMI_PERF_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_writebacks (perf_writebacks)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory returns a word derived from line address and beat index.
    function automatic logic [31:0] line_word(input logic [25:0] a, input int k);
        logic [3:0] kk;
        kk = k[3:0];
        return {kk, a ^ 26'h2AAAAAA, 2'b01};
    endfunction

    function automatic logic [511:0] model_line(input logic [25:0] a);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = line_word(a, k);
        return l;
    endfunction

    // ---------------- system memory responder ----------------
    logic ack_en;
    int   mem_beat;
    bit   acc;
    initial begin
        sm_ack = 1'b0; sm_rdata = '0; mem_beat = 0;
        forever begin
            @(negedge clk);
            acc = sm_request && sm_ack;
            @(posedge clk); #1;
            if (!sm_request) mem_beat = 0;
            else if (acc) mem_beat = mem_beat + 1;
            sm_ack   = ack_en && sm_request;
            sm_rdata = sm_request ? line_word(sm_address[31:6], mem_beat) : '0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [25:0]  addr;
        logic         dirty;
        logic [25:0]  wb_addr;
        logic [511:0] wb_data;
    } req_t;

    req_t mq[$];
    int   mbeat = 0;
    bit   m_wb_done = 0, m_fill_done = 0;
    bit   burst_end_prev = 0, last_fill_prev = 0, rv_prev = 0;

    always @(negedge clk) begin : compare
        req_t head, nr;
        bit   is_wb, can_enq;
        if (!reset_n) begin
            check("rst_outputs", {sm_request, sm_write, restart_valid, sm_address, sm_wdata,
                                  restart_address, pending_count}, '0);
            check("rst_restart_data", restart_data, '0);
            mq.delete();
            mbeat = 0; m_wb_done = 0; m_fill_done = 0;
            burst_end_prev = 0; last_fill_prev = 0; rv_prev = 0;
        end else begin
            check("pending_count", pending_count, mq.size());
            check("req_ready", req_ready, (mq.size() != 8));
            is_wb = 0;
            if (mq.size() != 0) begin
                head  = mq[0];
                is_wb = head.dirty && !m_wb_done;
            end
            if (sm_request) begin
                if (mq.size() == 0 || m_fill_done || burst_end_prev || restart_valid)
                    check("sm_request_unexpected", 1'b1, 1'b0);
                else if (is_wb) begin
                    check("wb_write", sm_write, 1'b1);
                    check("wb_address", sm_address, {head.wb_addr, 6'b0});
                    check("wb_wdata", sm_wdata, head.wb_data[32*mbeat +: 32]);
                end else begin
                    check("fill_write", sm_write, 1'b0);
                    check("fill_address", sm_address, {head.addr, 6'b0});
                end
            end
            if (restart_valid) begin
                if (mq.size() == 0 || !m_fill_done)
                    check("restart_unexpected", 1'b1, 1'b0);
                else begin
                    check("restart_address", restart_address, head.addr);
                    check("restart_data", restart_data, model_line(head.addr));
                end
                if (!rv_prev) check("restart_latency", last_fill_prev, 1'b1);
            end
            burst_end_prev = 0;
            last_fill_prev = 0;
            can_enq = (mq.size() != 8);
            if (sm_request && sm_ack && mq.size() != 0) begin
                mbeat++;
                if (mbeat == 16) begin
                    mbeat = 0;
                    burst_end_prev = 1;
                    if (is_wb) m_wb_done = 1;
                    else begin
                        m_fill_done    = 1;
                        last_fill_prev = 1;
                    end
                end
            end
            if (restart_valid && restart_ack && mq.size() != 0) begin
                void'(mq.pop_front());
                m_wb_done = 0; m_fill_done = 0; mbeat = 0;
            end
            if (req_valid && can_enq) begin
                nr.addr = req_address; nr.dirty = req_dirty;
                nr.wb_addr = req_wb_address; nr.wb_data = req_wb_data;
                mq.push_back(nr);
            end
            rv_prev = restart_valid;
        end
    end

    // ---------------- driver / wait tasks ----------------
    task automatic send_req(input logic [25:0] a, input logic d, input logic [25:0] wa,
                            input logic [511:0] wd);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_address = a; req_dirty = d;
        req_wb_address = wa; req_wb_data = wd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) check("timeout_send_req", 1'b0, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_sm_req(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sm_request) begin seen = 1; break; end
        end
        if (!seen) check(name, 1'b0, 1'b1);
    endtask

    task automatic wait_rv(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (restart_valid) begin seen = 1; break; end
        end
        if (!seen) check(name, 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pending_count == 0) begin seen = 1; break; end
        end
        if (!seen) check(name, 1'b0, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [511:0] wd;
        bit           seen_bad;
        reset_n = 1'b0; req_valid = 1'b0; req_address = '0; req_dirty = 1'b0;
        req_wb_address = '0; req_wb_data = '0; restart_ack = 1'b1; ack_en = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_pending_count", pending_count, 4'd0);
        check("reset_sm_request", sm_request, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;

        // clean miss
        send_req(26'h0000040, 1'b0, '0, '0);
        @(negedge clk);
        check("t1_pending_one", pending_count, 4'd1);
        wait_sm_req("timeout_t1_sm_request");
        check("t1_sm_address", sm_address, 32'h00001000);
        check("t1_sm_write", sm_write, 1'b0);
        wait_rv("timeout_t1_restart");
        check("t1_restart_address", restart_address, 26'h0000040);
        check("t1_data_beat0", restart_data[31:0], 32'h0AAAABA9);
        check("t1_data_beat15", restart_data[511:480], 32'hFAAAABA9);
        @(negedge clk);
        check("t1_pending_zero", pending_count, 4'd0);

        // full queue
        @(posedge clk); #1 ack_en = 1'b0;
        for (int i = 0; i < 8; i++) send_req(26'(32'h100 + i), 1'b0, '0, '0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_address = 26'h0003000; req_dirty = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_full_ready", req_ready, 1'b0);
            check("t3_full_count", pending_count, 4'd8);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; ack_en = 1'b1;
        wait_rv("timeout_t3_restart");
        check("t3_first_restart", restart_address, 26'h0000100);
        @(negedge clk);
        check("t3_ready_back", req_ready, 1'b1);
        check("t3_count_seven", pending_count, 4'd7);
        wait_drain("timeout_t3_drain");

        // restart back-pressure
        @(posedge clk); #1 restart_ack = 1'b0;
        send_req(26'h0123456, 1'b0, '0, '0);
        send_req(26'h3FFFFC0, 1'b0, '0, '0);
        wait_rv("timeout_t4_restart");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold", {restart_valid, restart_address, restart_data, sm_request},
                  {1'b1, 26'h0123456, model_line(26'h0123456), 1'b0});
        end
        check("t4_count_two", pending_count, 4'd2);
        @(posedge clk); #1 restart_ack = 1'b1;
        wait_drain("timeout_t4_drain");

        // reset mid-fill
        send_req(26'h0000200, 1'b0, '0, '0);
        wait_sm_req("timeout_t5_sm_request");
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t5_abort_sm", {sm_request, sm_write, sm_address}, '0);
        check("t5_abort_restart", {restart_valid, restart_address}, '0);
        check("t5_abort_count", pending_count, 4'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        seen_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (restart_valid || sm_request) seen_bad = 1;
        end
        check("t5_no_restart", seen_bad, 1'b0);

        // dirty miss
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = k;
        send_req(26'h0000050, 1'b1, 26'h0000010, wd);
        wait_sm_req("timeout_t2_wb");
        check("t2_wb_write", sm_write, 1'b1);
        check("t2_wb_address", sm_address, 32'h00000400);
        check("t2_wdata_0", sm_wdata, 32'd0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("t2_wdata", sm_wdata, 32'(k));
        end
        @(negedge clk);
        check("t2_gap", sm_request, 1'b0);
        wait_sm_req("timeout_t2_fill");
        check("t2_fill_write", sm_write, 1'b0);
        check("t2_fill_address", sm_address, 32'h00001400);
        wait_rv("timeout_t2_restart");
        check("t2_restart_address", restart_address, 26'h0000050);
        @(negedge clk);
        check("t2_pending_zero", pending_count, 4'd0);
`ifdef L2_SMI_PERF_EN
        check("perf_writebacks", perf_writebacks, 16'd1);
        check("perf_busy_cycles", perf_busy_cycles, 32'd35);
`endif

        repeat (5) @(negedge clk);
        check("model_drain", mq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
